// File: rtl/rvv_pkg.sv
// Types and width helpers shared by the RVV front end, command queue and backend issue.
// Pure declarations; no logic and no timing.
package rvv_pkg;

   localparam int ISSUE_LANE = 4;

   typedef struct packed {
      logic [7:0] op;
      logic [4:0] vd;
      logic [4:0] vs1;
      logic [4:0] vs2;
      logic [8:0] tag;
   } RVVCmd;

   // Bits needed to hold any count from 0 to n inclusive.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rvv_prefix_count.sv
// Counts the run of ones starting at bit 0 of a W-bit vector (prefix, not popcount).
// Purely combinational; no flow control of its own.
module rvv_prefix_count
   import rvv_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0]          vec,
   output logic [cnt_w(W)-1:0]   count
);

   localparam int CW = cnt_w(W);

   logic run;

   always_comb begin
      count = '0;
      run   = 1'b1;
      for (int i = 0; i < W; i++) begin
         if (run && vec[i]) begin
            count = CW'(i + 1);
         end else begin
            run = 1'b0;
         end
      end
   end

endmodule

// File: rtl/rvv_cmd_queue.sv
// Multi-lane in-order command queue: up to ENQ_W writes and DEQ_W prefix-contiguous pops per cycle.
// One-cycle enqueue-to-visible latency; producer is throttled by a clamped credit, excess lanes drop.
module rvv_cmd_queue
   import rvv_pkg::*;
#(
   parameter type T          = RVVCmd,
   parameter int  ENQ_W      = 4,
   parameter int  DEQ_W      = ISSUE_LANE,
   parameter int  DEPTH      = 16,
   parameter int  HEADROOM   = 4,
   parameter int  CREDIT_MAX = 2 * ENQ_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [cnt_w(ENQ_W)-1:0]      enq_count,
   input  T     [ENQ_W-1:0]             enq_data,
   output logic [cnt_w(CREDIT_MAX)-1:0] credit,
   output logic [DEQ_W-1:0]             deq_valid,
   output T     [DEQ_W-1:0]             deq_data,
   input  logic [DEQ_W-1:0]             deq_ready,
   output logic [cnt_w(DEPTH)-1:0]      fill,
   output logic                         overflow_err,
   output logic                         underflow_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FW = cnt_w(DEPTH);
   localparam int DW = cnt_w(DEQ_W);
   localparam int CW = cnt_w(CREDIT_MAX);

   T               mem [DEPTH];
   logic [PW-1:0]  head;
   logic [PW-1:0]  tail;
   logic [FW-1:0]  free_cnt;
   logic [FW-1:0]  enq_n;
   logic [DW-1:0]  deq_n;
   logic           ovf_hit;
   logic           udf_hit;
   logic signed [FW:0] avail;

   // Pointer advance modulo DEPTH with an explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [FW-1:0] n);
      logic [FW:0] s;
      s = (FW+1)'(p) + (FW+1)'(n);
      if (s > (FW+1)'(DEPTH - 1)) begin
         s = s - (FW+1)'(DEPTH);
      end
      return s[PW-1:0];
   endfunction

   always_comb begin
      for (int i = 0; i < DEQ_W; i++) begin
         deq_valid[i] = FW'(i) < fill;
         deq_data[i]  = mem[ptr_add(head, FW'(i))];
      end
   end

   rvv_prefix_count #(.W(DEQ_W)) u_deq_count (
      .vec   (deq_valid & deq_ready),
      .count (deq_n)
   );

   // Space freed by this cycle's pops is deliberately not reused until next cycle.
   assign free_cnt = FW'(DEPTH) - fill;
   assign ovf_hit  = FW'(enq_count) > free_cnt;
   assign enq_n    = ovf_hit ? free_cnt : FW'(enq_count);
   assign udf_hit  = |(deq_ready & ~deq_valid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         fill <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
         fill <= '0;
      end else begin
         head <= ptr_add(head, FW'(deq_n));
         tail <= ptr_add(tail, enq_n);
         fill <= fill + enq_n - FW'(deq_n);
      end
   end

   // Payload storage carries no reset; entries are only observed once fill covers them.
   always_ff @(posedge clk) begin
      for (int k = 0; k < ENQ_W; k++) begin
         if (!flush && (FW'(k) < enq_n)) begin
            mem[ptr_add(tail, FW'(k))] <= enq_data[k];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         if (ovf_hit) overflow_err  <= 1'b1;
         if (udf_hit) underflow_err <= 1'b1;
      end
   end

   // Signed and one bit wider than fill so a queue fuller than the headroom mark clamps to zero.
   assign avail = $signed((FW+1)'(DEPTH - HEADROOM)) - $signed({1'b0, fill});

   always_comb begin
      if (avail < 0) begin
         credit = '0;
      end else if (int'(avail) > CREDIT_MAX) begin
         credit = CW'(CREDIT_MAX);
      end else begin
         credit = CW'(avail);
      end
   end

endmodule

// File: tb/tb_rvv_cmd_queue.sv
// Directed bench for rvv_cmd_queue (ENQ_W=4, DEQ_W=4, DEPTH=16, HEADROOM=4, CREDIT_MAX=8).
module tb_rvv_cmd_queue;
   import rvv_pkg::*;

   logic           clk = 1'b0;
   logic           rst;
   logic           flush;
   logic [2:0]     enq_count;
   RVVCmd [3:0]    enq_data;
   logic [3:0]     credit;
   logic [3:0]     deq_valid;
   RVVCmd [3:0]    deq_data;
   logic [3:0]     deq_ready;
   logic [4:0]     fill;
   logic           overflow_err;
   logic           underflow_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rvv_cmd_queue #(
      .T(RVVCmd), .ENQ_W(4), .DEQ_W(4), .DEPTH(16), .HEADROOM(4), .CREDIT_MAX(8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .enq_count     (enq_count),
      .enq_data      (enq_data),
      .credit        (credit),
      .deq_valid     (deq_valid),
      .deq_data      (deq_data),
      .deq_ready     (deq_ready),
      .fill          (fill),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err)
   );

   typedef struct {
      logic       fl;
      logic [2:0] ecnt;
      logic [7:0] base;
      logic [3:0] rdy;
      logic [4:0] x_fill;
      logic [3:0] x_credit;
      logic [3:0] x_valid;
      logic [7:0] x_d0;
      logic [7:0] x_d3;
      logic       x_ovf;
      logic       x_udf;
   } vec_t;

   vec_t tbl [22];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic [2:0] ecnt, input logic [7:0] base, input logic [3:0] rdy);
      flush     = fl;
      enq_count = ecnt;
      deq_ready = rdy;
      for (int k = 0; k < 4; k++) enq_data[k] = RVVCmd'(32'(base) + 32'(k));
   endtask

   task automatic idle();
      drive(1'b0, 3'd0, 8'h00, 4'b0000);
   endtask

   initial begin
      logic [31:0] d;
      //          fl ecnt base  rdy      fill cr  valid    d0     d3     ovf udf
      tbl[0]  = '{0, 3'd4, 8'h10, 4'b0000, 5'd4,  4'd8, 4'b1111, 8'h10, 8'h13, 0, 0};
      tbl[1]  = '{0, 3'd4, 8'h14, 4'b0000, 5'd8,  4'd4, 4'b1111, 8'h10, 8'h13, 0, 0};
      tbl[2]  = '{0, 3'd4, 8'h18, 4'b0000, 5'd12, 4'd0, 4'b1111, 8'h10, 8'h13, 0, 0};
      tbl[3]  = '{0, 3'd0, 8'h00, 4'b1111, 5'd8,  4'd4, 4'b1111, 8'h14, 8'h17, 0, 0};
      tbl[4]  = '{0, 3'd0, 8'h00, 4'b0011, 5'd6,  4'd6, 4'b1111, 8'h16, 8'h19, 0, 0};
      tbl[5]  = '{0, 3'd0, 8'h00, 4'b1011, 5'd4,  4'd8, 4'b1111, 8'h18, 8'h1B, 0, 0};
      tbl[6]  = '{0, 3'd4, 8'h20, 4'b0000, 5'd8,  4'd4, 4'b1111, 8'h18, 8'h1B, 0, 0};
      tbl[7]  = '{0, 3'd0, 8'h00, 4'b1111, 5'd4,  4'd8, 4'b1111, 8'h20, 8'h23, 0, 0};
      tbl[8]  = '{0, 3'd0, 8'h00, 4'b0011, 5'd2,  4'd8, 4'b0011, 8'h22, 8'h00, 0, 0};
      tbl[9]  = '{0, 3'd4, 8'h30, 4'b1111, 5'd4,  4'd8, 4'b1111, 8'h30, 8'h33, 0, 1};
      tbl[10] = '{0, 3'd4, 8'h34, 4'b0000, 5'd8,  4'd4, 4'b1111, 8'h30, 8'h33, 0, 1};
      tbl[11] = '{0, 3'd4, 8'h38, 4'b0000, 5'd12, 4'd0, 4'b1111, 8'h30, 8'h33, 0, 1};
      tbl[12] = '{0, 3'd4, 8'h3C, 4'b0000, 5'd16, 4'd0, 4'b1111, 8'h30, 8'h33, 0, 1};
      tbl[13] = '{0, 3'd2, 8'h40, 4'b1111, 5'd12, 4'd0, 4'b1111, 8'h34, 8'h37, 1, 1};
      tbl[14] = '{0, 3'd0, 8'h00, 4'b1111, 5'd8,  4'd4, 4'b1111, 8'h38, 8'h3B, 1, 1};
      tbl[15] = '{0, 3'd0, 8'h00, 4'b1111, 5'd4,  4'd8, 4'b1111, 8'h3C, 8'h3F, 1, 1};
      tbl[16] = '{0, 3'd0, 8'h00, 4'b0011, 5'd2,  4'd8, 4'b0011, 8'h3E, 8'h00, 1, 1};
      tbl[17] = '{0, 3'd4, 8'h50, 4'b0000, 5'd6,  4'd6, 4'b1111, 8'h3E, 8'h51, 1, 1};
      tbl[18] = '{0, 3'd3, 8'h54, 4'b0000, 5'd9,  4'd3, 4'b1111, 8'h3E, 8'h51, 1, 1};
      tbl[19] = '{1, 3'd3, 8'h60, 4'b1111, 5'd0,  4'd8, 4'b0000, 8'h00, 8'h00, 1, 1};
      tbl[20] = '{0, 3'd4, 8'h70, 4'b0000, 5'd4,  4'd8, 4'b1111, 8'h70, 8'h73, 1, 1};
      tbl[21] = '{0, 3'd3, 8'h74, 4'b0000, 5'd7,  4'd5, 4'b1111, 8'h70, 8'h73, 1, 1};

      rst = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      check("reset fill",   32'(fill),          32'd0);
      check("reset credit", 32'(credit),        32'd8);
      check("reset valid",  32'(deq_valid),     32'd0);
      check("reset ovf",    32'(overflow_err),  32'd0);
      check("reset udf",    32'(underflow_err), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].fl, tbl[i].ecnt, tbl[i].base, tbl[i].rdy);
         @(posedge clk);
         #1;
         idle();
         @(negedge clk);
         check($sformatf("row%0d fill", i),   32'(fill),          32'(tbl[i].x_fill));
         check($sformatf("row%0d credit", i), 32'(credit),        32'(tbl[i].x_credit));
         check($sformatf("row%0d valid", i),  32'(deq_valid),     32'(tbl[i].x_valid));
         check($sformatf("row%0d ovf", i),    32'(overflow_err),  32'(tbl[i].x_ovf));
         check($sformatf("row%0d udf", i),    32'(underflow_err), 32'(tbl[i].x_udf));
         if (tbl[i].x_valid[0]) begin
            d = deq_data[0];
            check($sformatf("row%0d d0", i), d, 32'(tbl[i].x_d0));
         end
         if (tbl[i].x_valid[3]) begin
            d = deq_data[3];
            check($sformatf("row%0d d3", i), d, 32'(tbl[i].x_d3));
         end
      end

      // Asynchronous reset mid-cycle with fill=7 and both error flags set.
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("async rst fill",  32'(fill),          32'd0);
      check("async rst valid", 32'(deq_valid),     32'd0);
      check("async rst credit", 32'(credit),       32'd8);
      check("async rst ovf",   32'(overflow_err),  32'd0);
      check("async rst udf",   32'(underflow_err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 3'd2, 8'h80, 4'b0000);
      #1;
      check("no bypass fill",  32'(fill),      32'd0);
      check("no bypass valid", 32'(deq_valid), 32'd0);
      @(posedge clk);
      #1;
      idle();
      @(negedge clk);
      check("post rst fill",  32'(fill),      32'd2);
      check("post rst valid", 32'(deq_valid), 32'b0011);
      d = deq_data[0];
      check("post rst d0", d, 32'h80);
      d = deq_data[1];
      check("post rst d1", d, 32'h81);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
